cordic_round_ctrl: RTL and testbench
====================================

Name: cordic_round_ctrl

Overview:
- Iteration sequencer that sits directly upstream of the round counter (cntr).
- Accepts a start request and drives the counter's clr/c_up pins. Reads the round index back from the counter's q output.
- Issues load and iterate enables to the CORDIC datapath, then holds a done flag until the consumer acknowledges.
- One job = one load cycle followed by exactly NRND iteration cycles.

Parameters:
- rndw, 4, width of the round index; must match the counter's rndw.
- NRND, 16, iterations per job; legal range 1 .. 2^rndw.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  job request; sampled in IDLE, or in HOLD together with ack.
- abort  in  1  cancels a job in LOAD/ITER; no done is produced.
- rnd  in  rndw  round index from counter q.
- clr  out  1  to counter clr.
- c_up  out  1  to counter c_up.
- ld  out  1  datapath operand load strobe.
- en  out  1  datapath iteration enable; rnd is the current iteration index.
- last  out  1  high during the final iteration cycle.
- busy  out  1  high in LOAD, ITER and HOLD.
- done  out  1  result valid; held until ack.
- ack  in  1  consumer accepts result; meaningful only while done=1.

Behaviour:
- States: IDLE, LOAD, ITER, HOLD; binary encoded state register.
- Outputs are a combinational decode of (state, rnd). No extra registered delay.
- Reset: state=IDLE next edge. In IDLE all outputs are 0 (clr, c_up, ld, en, last, busy, done).
- IDLE:
  - start=1 → LOAD.
  - abort and ack are ignored.
- LOAD (exactly 1 cycle):
  - clr=1, ld=1, busy=1, c_up=0.
  - abort=1 → IDLE; otherwise → ITER.
- ITER:
  - en=1, busy=1.
  - If rnd != NRND-1: c_up=1, last=0, stay in ITER.
  - If rnd == NRND-1: c_up=0, last=1, → HOLD. The counter therefore parks at NRND-1 and never wraps.
  - abort=1 in any ITER cycle → IDLE, with c_up=0 in that cycle. The counter keeps its value; the next LOAD clears it.
- HOLD:
  - done=1, busy=1, en=0, c_up=0.
  - ack=0 → stay in HOLD.
  - ack=1 & start=0 → IDLE.
  - ack=1 & start=1 → LOAD (back-to-back job, no idle bubble).
  - abort is ignored in HOLD.
- clr and c_up are never both 1 in the same cycle; the counter gives c_up priority, so overlap would corrupt the clear.
- start while busy (except the HOLD+ack case) is ignored, not queued.
- Latency: start sampled at edge k → LOAD in cycle k+1 → ITER in cycles k+2 .. k+NRND+1 → done=1 from cycle k+NRND+2.
- NRND=1: ITER lasts a single cycle with last=1 and c_up=0.
- rst has priority over every input in every state. rst mid-job → IDLE with no done. The counter value is stale but unused until the next LOAD.
- rnd is compared at full rndw width, unsigned. Values above NRND-1 cannot occur in normal operation. If one appears in ITER (counter corrupted), treat it as not-last: continue counting, c_up=1.

Test Plan:
- Reset, then single job (rndw=4, NRND=16, cntr attached). Pulse start → ld/clr high 1 cycle; en high 16 cycles with rnd 0..15; last only at rnd=15; done rises at cycle 18 after the start edge; counter holds 15.
- done held with ack=0 for 10 cycles → done, busy stay 1; en, c_up stay 0. Then ack=1 → IDLE next cycle, all outputs 0.
- HOLD with ack=1 and start=1 in the same cycle → LOAD the next cycle; counter reads 0 in the first ITER cycle; second job completes in the same 18-cycle latency.
- abort at rnd=7 → c_up=0 that cycle, IDLE next, no done. Then a new start → full 16-iteration job starting from rnd=0.
- rst asserted during ITER at rnd=9 → IDLE next edge, all outputs 0. start during LOAD, ITER or HOLD without ack → no effect.
- NRND=1 build: start → LOAD, one ITER cycle (en=1, last=1, c_up=0), done on the third cycle after the start edge. Assertion on every test: never clr&c_up.

Source files
------------

// File: rtl/cordic_round_ctrl_if.sv
// Handshake bundle between the CORDIC round sequencer and its environment:
// job control, counter feedback/drive and datapath strobes.
interface cordic_round_ctrl_if #(
  parameter int rndw = 4
);
  logic            start;
  logic            abort;
  logic            ack;
  logic [rndw-1:0] rnd;
  logic            clr;
  logic            c_up;
  logic            ld;
  logic            en;
  logic            last;
  logic            busy;
  logic            done;

  modport master (
    output start, abort, ack, rnd,
    input  clr, c_up, ld, en, last, busy, done
  );

  modport slave (
    input  start, abort, ack, rnd,
    output clr, c_up, ld, en, last, busy, done
  );
endinterface

// File: rtl/cordic_round_ctrl.sv
// CORDIC iteration sequencer: one operand load, then NRND iterations counted by
// an external round counter, then a done flag held until acknowledged.
module cordic_round_ctrl #(
  parameter int rndw = 4,
  parameter int NRND = 16
) (
  input  logic               clk,
  input  logic               rst,
  cordic_round_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ITER = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [rndw-1:0] LAST_RND = rndw'(NRND - 1);

  state_t state_r;
  state_t state_nxt_s;

  logic clr_s;
  logic c_up_s;
  logic ld_s;
  logic en_s;
  logic last_s;
  logic busy_s;
  logic done_s;
  logic rnd_last_s;

  // Full-width unsigned compare: a corrupted index above LAST_RND is not-last,
  // so the job keeps counting instead of finishing early.
  function automatic logic is_last_rnd(input logic [rndw-1:0] r);
    return (r == LAST_RND);
  endfunction

  assign rnd_last_s = is_last_rnd(bus.rnd);

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and output decode from (state, rnd, control inputs)
  always_comb begin
    state_nxt_s = state_r;
    clr_s       = 1'b0;
    c_up_s      = 1'b0;
    ld_s        = 1'b0;
    en_s        = 1'b0;
    last_s      = 1'b0;
    busy_s      = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt_s = S_LOAD;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_LOAD: begin
        clr_s  = 1'b1;
        ld_s   = 1'b1;
        busy_s = 1'b1;
        if (bus.abort) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_ITER;
        end
      end
      S_ITER: begin
        en_s   = 1'b1;
        busy_s = 1'b1;
        last_s = rnd_last_s;
        // c_up stays low on the final round so the counter parks at NRND-1
        if (bus.abort) begin
          state_nxt_s = S_IDLE;
        end else if (rnd_last_s) begin
          state_nxt_s = S_HOLD;
        end else begin
          c_up_s      = 1'b1;
          state_nxt_s = S_ITER;
        end
      end
      S_HOLD: begin
        done_s = 1'b1;
        busy_s = 1'b1;
        if (bus.ack) begin
          if (bus.start) begin
            state_nxt_s = S_LOAD;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end else begin
          state_nxt_s = S_HOLD;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  assign bus.clr  = clr_s;
  assign bus.c_up = c_up_s;
  assign bus.ld   = ld_s;
  assign bus.en   = en_s;
  assign bus.last = last_s;
  assign bus.busy = busy_s;
  assign bus.done = done_s;

endmodule

// File: tb/tb_cordic_round_ctrl.sv
// Bench for cordic_round_ctrl: NRND=16 and NRND=1 instances, each with a round
// counter, checked every cycle against a job-level model plus literal pins.
module tb_cordic_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst   = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic ack   = 1'b0;

  int n_cmp  = 0;
  int n_err  = 0;
  bit chk_en = 1'b0;

  cordic_round_ctrl_if #(.rndw(4)) if0 ();
  cordic_round_ctrl_if #(.rndw(4)) if1 ();

  cordic_round_ctrl #(.rndw(4), .NRND(16)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  cordic_round_ctrl #(.rndw(4), .NRND(1))  dut1 (.clk(clk), .rst(rst), .bus(if1));

  logic [3:0] q0 = 4'd0;
  logic [3:0] q1 = 4'd0;

  assign if0.start = start;
  assign if0.abort = abort;
  assign if0.ack   = ack;
  assign if0.rnd   = q0;
  assign if1.start = start;
  assign if1.abort = abort;
  assign if1.ack   = ack;
  assign if1.rnd   = q1;

  // Round counters (cntr behaviour): c_up has priority over clr, no reset
  always @(posedge clk) begin
    if (if0.c_up) q0 <= q0 + 4'd1;
    else if (if0.clr) q0 <= 4'd0;
    if (if1.c_up) q1 <= q1 + 4'd1;
    else if (if1.clr) q1 <= 4'd0;
  end

  logic [6:0] outs0;
  logic [6:0] outs1;
  assign outs0 = {if0.clr, if0.c_up, if0.ld, if0.en, if0.last, if0.busy, if0.done};
  assign outs1 = {if1.clr, if1.c_up, if1.ld, if1.en, if1.last, if1.busy, if1.done};

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Job model: phase 0 idle, 1 load, 2 iterating (index k), 3 holding result
  int nr   [2] = '{16, 1};
  int m_ph [2] = '{0, 0};
  int m_k  [2] = '{0, 0};

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic [6:0] e;
        logic [6:0] a;
        int q;
        int n;
        int k;
        n = nr[i];
        k = m_k[i];
        a = (i == 0) ? outs0 : outs1;
        q = (i == 0) ? int'(q0) : int'(q1);
        e = 7'd0;
        if (m_ph[i] == 1) e = 7'b1010010;
        if (m_ph[i] == 2) e = {1'b0, (!abort && (k != n - 1)), 1'b0, 1'b1, (k == n - 1), 1'b1, 1'b0};
        if (m_ph[i] == 3) e = 7'b0000011;
        chk($sformatf("outs%0d", i), int'(a), int'(e));
        chk($sformatf("no_clr_cup%0d", i), int'(a[6] & a[5]), 0);
        if (m_ph[i] == 2) chk($sformatf("rnd_iter%0d", i), q, k);
        if (m_ph[i] == 3) chk($sformatf("rnd_hold%0d", i), q, n - 1);
        if (m_ph[i] == 0) begin
          if (start) m_ph[i] = 1;
        end else if (m_ph[i] == 1) begin
          m_ph[i] = abort ? 0 : 2;
          m_k[i]  = 0;
        end else if (m_ph[i] == 2) begin
          if (abort) m_ph[i] = 0;
          else if (k == n - 1) m_ph[i] = 3;
          else m_k[i] = k + 1;
        end else begin
          if (ack) m_ph[i] = start ? 1 : 0;
        end
        if (rst) m_ph[i] = 0;
      end
    end
  end

  // Launch a job (optionally with ack, for a back-to-back start from HOLD)
  task automatic measure(input bit with_ack);
    int lat0;
    int lat1;
    int en0;
    int last0;
    lat0 = 0; lat1 = 0; en0 = 0; last0 = 0;
    start = 1'b1;
    ack   = with_ack;
    step();
    start = 1'b0;
    ack   = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (if0.en) en0++;
      if (if0.last) last0++;
      if (if0.done && lat0 == 0) lat0 = c;
      if (if1.done && lat1 == 0) lat1 = c;
    end
    chk("latency16", lat0, 18);
    chk("latency1", lat1, 3);
    chk("en_cycles16", en0, 16);
    chk("last_cycles16", last0, 1);
    chk("done_held", int'(if0.done), 1);
    chk("hold_rnd16", int'(q0), 15);
  endtask

  task automatic wait_rnd(input int v);
    bit found;
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      if (if0.en && int'(if0.rnd) == v) found = 1'b1;
    end
    chk("wait_rnd", int'(found), 1);
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    rst    = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_outs0", int'(outs0), 0);
    chk("reset_outs1", int'(outs1), 0);

    step();
    measure(1'b0);
    measure(1'b1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    @(negedge clk);
    chk("idle_after_ack0", int'(outs0), 0);
    chk("idle_after_ack1", int'(outs1), 0);

    // Abort at round 7 on the long job; the NRND=1 instance sits in HOLD
    start = 1'b1;
    step();
    start = 1'b0;
    wait_rnd(6);
    step();
    abort = 1'b1;
    @(negedge clk);
    chk("abort_rnd", int'(if0.rnd), 7);
    chk("abort_cup", int'(if0.c_up), 0);
    step();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(if0.busy), 0);
    chk("abort_done", int'(if0.done), 0);
    chk("abort_ignored_hold", int'(if1.done), 1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    measure(1'b0);
    ack = 1'b1;
    step();
    ack = 1'b0;

    // Stray starts mid-job, then reset at round 9
    start = 1'b1;
    step();
    start = 1'b0;
    wait_rnd(2);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_rnd(8);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rnd", int'(if0.rnd), 9);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_outs0", int'(outs0), 0);
    chk("rst_outs1", int'(outs1), 0);

    for (int c = 0; c < 4000; c++) begin
      rst   = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 24) == 0);
      ack   = ($urandom_range(0, 2) == 0);
      step();
    end
    rst   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    ack   = 1'b0;
    step();
    step();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
